// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port sequencer: clears NREGS entries after reset, then round-robin arbitrates NREQ writers (1-cycle write latency).
// Requests are held off (req_ready=0) during the sweep and reset; ZERO_REG_PROTECT_EN suppresses RUN-time writes to address 0.
module regfile_wr_arbiter #(
    parameter int            DW       = 32,
    parameter int            AW       = 5,
    parameter int            NREGS    = 32,
    parameter int            NREQ     = 2,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_addr,
    output logic [DW-1:0]            rf_wdata,
    output logic                     init_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [AW-1:0]   cnt;
    logic [GW-1:0]   rrPtr;
    logic            rfWe;
    logic [AW-1:0]   rfAddr;
    logic [DW-1:0]   rfWdata;
    logic            initBusy;
    logic [GW-1:0]   grantId;

    logic            grantVld;
    logic [GW-1:0]   grantIdx;
    logic [GW:0]     scanSum;
    logic [GW-1:0]   scanIdx;
    logic [GW-1:0]   rrNext;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    logic            acceptWe;
    logic            lastInit;

    assign lastInit = (cnt == AW'(NREGS - 1));

    // Scan from highest offset down so the lowest offset from rrPtr wins.
    always_comb begin
        grantVld = 1'b0;
        grantIdx = '0;
        scanSum  = '0;
        scanIdx  = '0;
        if (state == RUN && !rst) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                scanSum = {1'b0, rrPtr} + (GW+1)'(k);
                if (scanSum >= (GW+1)'(NREQ)) begin
                    scanSum = scanSum - (GW+1)'(NREQ);
                end
                scanIdx = scanSum[GW-1:0];
                if (req_valid[scanIdx]) begin
                    grantVld = 1'b1;
                    grantIdx = scanIdx;
                end
            end
        end
    end

    assign req_ready = grantVld ? (NREQ'(1) << grantIdx) : '0;
    assign selAddr   = req_addr[grantIdx*AW +: AW];
    assign selData   = req_data[grantIdx*DW +: DW];
    assign rrNext    = (grantIdx == GW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;

`ifdef ZERO_REG_PROTECT_EN
    assign acceptWe = grantVld && (selAddr != '0);
`else
    assign acceptWe = grantVld;
`endif

    always_comb begin
        stateNext = state;
        if (state == INIT && lastInit) begin
            stateNext = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rrPtr    <= '0;
            initBusy <= 1'b1;
            rfWe     <= 1'b0;
            rfAddr   <= '0;
            rfWdata  <= '0;
            grantId  <= '0;
        end else if (state == INIT) begin
            rfWe    <= 1'b1;
            rfAddr  <= cnt;
            rfWdata <= INIT_VAL;
            cnt     <= cnt + 1'b1;
            if (lastInit) begin
                initBusy <= 1'b0;
            end
        end else begin
            rfWe <= acceptWe;
            // Address/data/grant track every accept, even a suppressed zero-address one.
            if (grantVld) begin
                rfAddr  <= selAddr;
                rfWdata <= selData;
                grantId <= grantIdx;
                rrPtr   <= rrNext;
            end
        end
    end

    assign rf_we     = rfWe;
    assign rf_addr   = rfAddr;
    assign rf_wdata  = rfWdata;
    assign init_busy = initBusy;
    assign grant_id  = grantId;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: init sweep, hold-off, round-robin vectors, mid-run and mid-sweep reset.
module tb_regfile_wr_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;
    localparam int NREQ  = 2;
`ifdef ZERO_REG_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ*AW-1:0]  reqAddr;
    logic [NREQ*DW-1:0]  reqData;
    logic [NREQ-1:0]     reqReady;
    logic                rfWe;
    logic [AW-1:0]       rfAddr;
    logic [DW-1:0]       rfWdata;
    logic                initBusy;
    logic                grantId;

    int checks   = 0;
    int failures = 0;

    regfile_wr_arbiter #(
        .DW(DW), .AW(AW), .NREGS(NREGS), .NREQ(NREQ), .INIT_VAL('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_addr  (reqAddr),
        .req_data  (reqData),
        .req_ready (reqReady),
        .rf_we     (rfWe),
        .rf_addr   (rfAddr),
        .rf_wdata  (rfWdata),
        .init_busy (initBusy),
        .grant_id  (grantId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [1:0]  expRdy;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        logic        expGid;
        logic        chkData;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_we"},    64'(rfWe),     64'd0);
        chk({tag, "_addr"},  64'(rfAddr),   64'd0);
        chk({tag, "_wdata"}, 64'(rfWdata),  64'd0);
        chk({tag, "_busy"},  64'(initBusy), 64'd1);
        chk({tag, "_gid"},   64'(grantId),  64'd0);
        chk({tag, "_ready"}, 64'(reqReady), 64'd0);
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        reqValid = v;
        reqAddr  = {a1, a0};
        reqData  = {d1, d0};
    endtask

    initial begin
        vecs[0]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    2'b00, 1'b0, 5'd9,  32'hA5A5,     1'b1, 1'b1};
        vecs[1]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,    2'b01, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{2'b10, 5'd0,  32'h0,        5'd20, 32'h1111, 2'b10, 1'b1, 5'd20, 32'h1111,     1'b1, 1'b1};
        vecs[3]  = '{2'b11, 5'd3,  32'h33,       5'd7,  32'h77,   2'b01, 1'b1, 5'd3,  32'h33,       1'b0, 1'b1};
        vecs[4]  = '{2'b11, 5'd3,  32'h33,       5'd7,  32'h77,   2'b10, 1'b1, 5'd7,  32'h77,       1'b1, 1'b1};
        vecs[5]  = '{2'b11, 5'd3,  32'h33,       5'd7,  32'h77,   2'b01, 1'b1, 5'd3,  32'h33,       1'b0, 1'b1};
        vecs[6]  = '{2'b11, 5'd3,  32'h33,       5'd7,  32'h77,   2'b10, 1'b1, 5'd7,  32'h77,       1'b1, 1'b1};
        vecs[7]  = '{2'b00, 5'd3,  32'h33,       5'd7,  32'h77,   2'b00, 1'b0, 5'd7,  32'h77,       1'b1, 1'b1};
        vecs[8]  = '{2'b11, 5'd12, 32'hAAAA,     5'd12, 32'hBBBB, 2'b01, 1'b1, 5'd12, 32'hAAAA,     1'b0, 1'b1};
        vecs[9]  = '{2'b10, 5'd12, 32'hAAAA,     5'd12, 32'hBBBB, 2'b10, 1'b1, 5'd12, 32'hBBBB,     1'b1, 1'b1};
        vecs[10] = '{2'b10, 5'd0,  32'h0,        5'd4,  32'h44,   2'b10, 1'b1, 5'd4,  32'h44,       1'b1, 1'b1};
        vecs[11] = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,    2'b01, !ZP,  5'd0,  32'h1234,     1'b0, !ZP};
        vecs[12] = '{2'b01, 5'd1,  32'h5678,     5'd0,  32'h0,    2'b01, 1'b1, 5'd1,  32'h5678,     1'b0, 1'b1};

        // Reset with requester 1 already waiting; it must be held off through the sweep.
        rst = 1'b1;
        drive(2'b10, 5'd0, 32'h0, 5'd9, 32'hA5A5);
        repeat (2) @(posedge clk);
        #1;
        chkReset("reset");
        rst = 1'b0;

        for (int i = 0; i < NREGS; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep%0d_we", i),    64'(rfWe),     64'd1);
            chk($sformatf("sweep%0d_addr", i),  64'(rfAddr),   64'(i));
            chk($sformatf("sweep%0d_wdata", i), 64'(rfWdata),  64'd0);
            chk($sformatf("sweep%0d_busy", i),  64'(initBusy), (i < NREGS - 1) ? 64'd1 : 64'd0);
            chk($sformatf("sweep%0d_ready", i), 64'(reqReady), (i < NREGS - 1) ? 64'd0 : 64'b10);
        end
        @(posedge clk); #1;
        chk("holdoff_we",    64'(rfWe),    64'd1);
        chk("holdoff_addr",  64'(rfAddr),  64'd9);
        chk("holdoff_wdata", 64'(rfWdata), 64'hA5A5);
        chk("holdoff_gid",   64'(grantId), 64'd1);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(reqReady), 64'(vecs[i].expRdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_we", i),  64'(rfWe),    64'(vecs[i].expWe));
            chk($sformatf("vec%0d_gid", i), 64'(grantId), 64'(vecs[i].expGid));
            if (vecs[i].chkData) begin
                chk($sformatf("vec%0d_addr", i),  64'(rfAddr),  64'(vecs[i].expAddr));
                chk($sformatf("vec%0d_wdata", i), 64'(rfWdata), 64'(vecs[i].expData));
            end
        end

        // Reset during RUN: ready must drop while rst is high, even before the edge.
        drive(2'b01, 5'd2, 32'h22, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        chk("runrst_ready", 64'(reqReady), 64'd0);
        @(posedge clk); #1;
        chkReset("runrst");
        rst = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        for (int i = 0; i <= 17; i++) begin
            @(posedge clk); #1;
            chk($sformatf("part%0d_addr", i), 64'(rfAddr), 64'(i));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chkReset("sweeprst");
        rst = 1'b0;

        for (int i = 0; i < NREGS; i++) begin
            @(posedge clk); #1;
            chk($sformatf("resweep%0d_we", i),   64'(rfWe),     64'd1);
            chk($sformatf("resweep%0d_addr", i), 64'(rfAddr),   64'(i));
            chk($sformatf("resweep%0d_busy", i), 64'(initBusy), (i < NREGS - 1) ? 64'd1 : 64'd0);
        end
        @(posedge clk); #1;
        chk("idle_we", 64'(rfWe), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
